// File: rtl/lieat_vreg_wbpack_if.sv
// lieat_vreg_wbpack_if: command, element and vregfile group-write signals of the writeback packer
interface lieat_vreg_wbpack_if #(
  parameter int XLEN = 32,
  parameter int REG_IDX = 5,
  parameter int VL_W = 6
);
  logic cmd_valid;
  logic cmd_ready;
  logic [REG_IDX-1:0] cmd_rd;
  logic [VL_W-1:0] cmd_vl;
  logic [1:0] cmd_sew;
  logic cmd_vm;
  logic [XLEN-1:0] cmd_mask;
  logic elem_valid;
  logic elem_ready;
  logic [XLEN-1:0] elem_data;
  logic vreg_wvalid;
  logic [REG_IDX-1:0] vreg_rd0;
  logic [7:0][3:0] vreg_wmask;
  logic [7:0][XLEN-1:0] vreg_wdata;
  modport slave (
    input cmd_valid, cmd_rd, cmd_vl, cmd_sew, cmd_vm, cmd_mask, elem_valid, elem_data,
    output cmd_ready, elem_ready, vreg_wvalid, vreg_rd0, vreg_wmask, vreg_wdata
  );
  modport master (
    output cmd_valid, cmd_rd, cmd_vl, cmd_sew, cmd_vm, cmd_mask, elem_valid, elem_data,
    input cmd_ready, elem_ready, vreg_wvalid, vreg_rd0, vreg_wmask, vreg_wdata
  );
endinterface

// File: rtl/lieat_vreg_wbpack.sv
// lieat_vreg_wbpack: packs SEW-sized lane results into an 8-register group and issues one group write
module lieat_vreg_wbpack #(
  parameter int XLEN = 32,
  parameter int REG_IDX = 5,
  parameter int VL_W = 6
) (
  input  logic clock,
  input  logic reset,
  lieat_vreg_wbpack_if.slave bus,
  output logic done,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;
  state_t state, state_nx;
  logic [VL_W-1:0] idx, vl_eff, vl_max, vl_in;
  logic [REG_IDX-1:0] rd;
  logic [1:0] sew, sew_in;
  logic vm, acc, take, last, cmd_acc;
  logic [XLEN-1:0] mask, dm;
  logic [7:0][XLEN-1:0] dbuf;
  logic [7:0][3:0] mbuf;
  logic [4:0] off;
  logic [3:0] sz;
  always_comb begin
    sew_in = bus.cmd_sew == 2'b11 ? 2'b10 : bus.cmd_sew;
    vl_max = VL_W'(32) >> sew_in;
    vl_in = bus.cmd_vl > vl_max ? vl_max : bus.cmd_vl;
    off = idx[4:0] << sew;
    sz = sew == 2'b00 ? 4'h1 : sew == 2'b01 ? 4'h3 : 4'hF;
    dm = {{8{sz[3]}}, {8{sz[2]}}, {8{sz[1]}}, {8{sz[0]}}};
    cmd_acc = state == IDLE && bus.cmd_valid;
    acc = state == COLLECT && bus.elem_valid;
    take = vm | mask[idx[4:0]];
    last = idx == vl_eff - 1'b1;
    state_nx = state == IDLE ? (cmd_acc ? (vl_in != '0 ? COLLECT : WRITE) : IDLE)
             : state == COLLECT ? (acc && last ? WRITE : COLLECT) : IDLE;
    bus.cmd_ready = state == IDLE;
    bus.elem_ready = state == COLLECT;
    busy = state != IDLE;
    done = state == WRITE;
    bus.vreg_wvalid = done && vl_eff != '0;
    bus.vreg_rd0 = rd;
    bus.vreg_wmask = done ? mbuf : '0;
    bus.vreg_wdata = done ? dbuf : '0;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // Buffers start cleared, so unaccepted tail bytes and masked-off elements stay zero
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      idx <= '0;
      vl_eff <= '0;
      rd <= '0;
      sew <= '0;
      vm <= 1'b0;
      mask <= '0;
      dbuf <= '0;
      mbuf <= '0;
    end else if (cmd_acc) begin
      idx <= '0;
      vl_eff <= vl_in;
      rd <= bus.cmd_rd;
      sew <= sew_in;
      vm <= bus.cmd_vm;
      mask <= bus.cmd_mask;
      dbuf <= '0;
      mbuf <= '0;
    end else if (acc) begin
      idx <= idx + 1'b1;
      if (take) begin
        dbuf[off[4:2]] <= dbuf[off[4:2]] | ((bus.elem_data & dm) << {off[1:0], 3'b000});
        mbuf[off[4:2]] <= mbuf[off[4:2]] | (sz << off[1:0]);
      end
    end
endmodule

// File: tb/tb_lieat_vreg_wbpack.sv
// tb_lieat_vreg_wbpack: directed vectors with hand-computed group writes
module tb_lieat_vreg_wbpack;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic done, busy;
  int errors = 0;
  int checks = 0;
  int wcount = 0;
  int wc_before;
  logic [255:0] e_seq;
  lieat_vreg_wbpack_if bus();
  lieat_vreg_wbpack dut (.clock(clock), .reset(reset), .bus(bus), .done(done), .busy(busy));
  always #5 clock = ~clock;
  always @(negedge clock) if (bus.vreg_wvalid === 1'b1) wcount++;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic send_cmd(input logic [4:0] rd, input logic [5:0] vl, input logic [1:0] sew,
                          input logic vm, input logic [31:0] mask);
    bus.cmd_valid = 1'b1;
    bus.cmd_rd = rd;
    bus.cmd_vl = vl;
    bus.cmd_sew = sew;
    bus.cmd_vm = vm;
    bus.cmd_mask = mask;
    tick;
    bus.cmd_valid = 1'b0;
  endtask
  task automatic send_elem(input logic [31:0] d);
    bus.elem_valid = 1'b1;
    bus.elem_data = d;
    tick;
    bus.elem_valid = 1'b0;
  endtask
  task automatic check_write(input string tag, input logic [4:0] rd, input logic [31:0] wm,
                             input logic [255:0] wd);
    check({tag, "_wvalid"}, 256'(bus.vreg_wvalid), 256'(1));
    check({tag, "_done"}, 256'(done), 256'(1));
    check({tag, "_rd0"}, 256'(bus.vreg_rd0), 256'(rd));
    check({tag, "_wmask"}, 256'(bus.vreg_wmask), 256'(wm));
    check({tag, "_wdata"}, bus.vreg_wdata, wd);
    check({tag, "_eready"}, 256'(bus.elem_ready), 256'(0));
    tick;
    check({tag, "_ready_after"}, 256'(bus.cmd_ready), 256'(1));
    check({tag, "_wvalid_after"}, 256'({bus.vreg_wvalid, done, busy}), 256'(0));
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_rd = '0;
    bus.cmd_vl = '0;
    bus.cmd_sew = '0;
    bus.cmd_vm = 1'b0;
    bus.cmd_mask = '0;
    bus.elem_valid = 1'b0;
    bus.elem_data = '0;
    for (int k = 0; k < 8; k++) e_seq[k*32 +: 32] = 32'h11111111 * (k + 1);
    #12;
    check("rst_ctl", 256'({bus.vreg_wvalid, done, busy}), 256'(0));
    check("rst_rd0", 256'(bus.vreg_rd0), 256'(0));
    check("rst_wmask", 256'(bus.vreg_wmask), 256'(0));
    check("rst_wdata", bus.vreg_wdata, 256'(0));
    reset = 1'b1;
    tick;
    check("rst_cmd_ready", 256'(bus.cmd_ready), 256'(1));
    send_cmd(5'd8, 6'd8, 2'b10, 1'b1, 32'h0);
    check("collect_ctl", 256'({bus.cmd_ready, bus.elem_ready, busy}), 256'(3'b011));
    for (int k = 0; k < 8; k++) send_elem(e_seq[k*32 +: 32]);
    check_write("sew32", 5'd8, 32'hFFFFFFFF, e_seq);
    send_cmd(5'd0, 6'd5, 2'b00, 1'b1, 32'h0);
    for (int k = 0; k < 5; k++) send_elem(32'hFFFFFFA0 + k);
    check_write("sew8", 5'd0, 32'h0000001F, {192'b0, 32'h000000A4, 32'hA3A2A1A0});
    send_cmd(5'd16, 6'd4, 2'b01, 1'b0, 32'b0101);
    send_elem(32'hBEEF1111);
    send_elem(32'h00002222);
    send_elem(32'h00003333);
    send_elem(32'h00004444);
    check_write("sew16m", 5'd16, 32'h00000033, {192'b0, 32'h00003333, 32'h00001111});
    send_cmd(5'd2, 6'd20, 2'b10, 1'b1, 32'h0);
    for (int k = 0; k < 8; k++) send_elem(e_seq[k*32 +: 32]);
    check_write("clamp", 5'd2, 32'hFFFFFFFF, e_seq);
    send_cmd(5'd5, 6'd0, 2'b10, 1'b1, 32'h0);
    check("zero_done", 256'({done, bus.vreg_wvalid, busy}), 256'(3'b101));
    check("zero_wmask", 256'(bus.vreg_wmask), 256'(0));
    tick;
    check("zero_ready", 256'({bus.cmd_ready, done}), 256'(2'b10));
    send_cmd(5'd8, 6'd8, 2'b10, 1'b1, 32'h0);
    for (int k = 0; k < 8; k++) begin
      send_elem(e_seq[k*32 +: 32]);
      if (k != 7) begin
        tick;
        if (k == 3) check("gap_hold", 256'({bus.elem_ready, busy, done}), 256'(3'b110));
      end
    end
    check_write("gap", 5'd8, 32'hFFFFFFFF, e_seq);
    send_cmd(5'd3, 6'd8, 2'b10, 1'b1, 32'h0);
    for (int k = 0; k < 3; k++) send_elem(e_seq[k*32 +: 32]);
    wc_before = wcount;
    #3 reset = 1'b0;
    #1;
    check("arst_ctl", 256'({busy, bus.elem_ready, bus.vreg_wvalid, done}), 256'(0));
    check("arst_rd0", 256'(bus.vreg_rd0), 256'(0));
    repeat (2) tick;
    reset = 1'b1;
    tick;
    check("arst_no_write", 256'(wcount), 256'(wc_before));
    check("arst_ready", 256'(bus.cmd_ready), 256'(1));
    send_cmd(5'd31, 6'd1, 2'b10, 1'b1, 32'h0);
    send_elem(32'hDEADBEEF);
    check_write("post_rst", 5'd31, 32'h0000000F, {224'b0, 32'hDEADBEEF});
    check("write_count", 256'(wcount), 256'(6));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
